// File: rtl/adder_acc_pkg.sv
// Shared types and defaults for the adder result accumulator.
package adder_acc_pkg;

  typedef enum logic [0:0] {
    StAccum,
    StHold
  } acc_state_e;

  localparam int unsigned DefAccWidth = 32;
  localparam int unsigned DefCount    = 8;

  // Width needed to hold a count in the range 0..count.
  function automatic int unsigned cnt_width(input int unsigned count);
    return $clog2(count + 1);
  endfunction

endpackage

// File: rtl/adder_acc_add.sv
// Combinational accumulator adder with carry-out.
// ADDER_ACC_SAT_EN selects clamping to all ones on carry instead of wrapping.
module adder_acc_add #(
  parameter int unsigned ACC_WIDTH = 32
) (
  input  logic [ACC_WIDTH-1:0] a_i,
  input  logic [ACC_WIDTH-1:0] b_i,
  output logic [ACC_WIDTH-1:0] sum_o,
  output logic                 carry_o
);

  logic [ACC_WIDTH:0] full_sum;

  assign full_sum = {1'b0, a_i} + {1'b0, b_i};
  assign carry_o  = full_sum[ACC_WIDTH];

`ifdef ADDER_ACC_SAT_EN
  // Once clamped, further adds either carry again or add zero, so it stays clamped.
  assign sum_o = carry_o ? {ACC_WIDTH{1'b1}} : full_sum[ACC_WIDTH-1:0];
`else
  assign sum_o = full_sum[ACC_WIDTH-1:0];
`endif

endmodule

// File: rtl/adder_result_accumulator.sv
// Accumulates frames of {cout, sum} adder results and emits each frame total on a
// valid/ready port. Saturating accumulation is selected with ADDER_ACC_SAT_EN.
module adder_result_accumulator
  import adder_acc_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = DefAccWidth,
  parameter int unsigned COUNT     = DefCount
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_sum,
  input  logic                          in_cout,
  input  logic                          flush,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ACC_WIDTH-1:0]          out_acc,
  output logic [cnt_width(COUNT)-1:0]   out_count,
  output logic                          out_ovf
);

  localparam int unsigned CntW = cnt_width(COUNT);

  acc_state_e            state_q, state_d;
  logic [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic [ACC_WIDTH-1:0]  out_acc_q, out_acc_d;
  logic [CntW-1:0]       out_count_q, out_count_d;
  logic                  out_ovf_q, out_ovf_d;

  logic [ACC_WIDTH-1:0]  value;
  logic [ACC_WIDTH-1:0]  add_sum;
  logic                  add_carry;
  logic                  accept;
  logic [ACC_WIDTH-1:0]  acc_upd;
  logic [CntW-1:0]       cnt_upd;
  logic                  ovf_upd;
  logic                  close;

  always_comb begin
    value            = '0;
    value[WIDTH:0]   = {in_cout, in_sum};
  end

  adder_acc_add #(
    .ACC_WIDTH (ACC_WIDTH)
  ) u_add (
    .a_i     (acc_q),
    .b_i     (value),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // Handshake signals come straight from state, so out_ready never reaches in_ready.
  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign accept    = in_valid && in_ready;

  always_comb begin
    acc_upd = accept ? add_sum : acc_q;
    cnt_upd = accept ? cnt_q + CntW'(1) : cnt_q;
    ovf_upd = ovf_q | (accept & add_carry);
    close   = (state_q == StAccum) &&
              ((accept && (cnt_q == CntW'(COUNT - 1))) ||
               (flush && ((cnt_q != '0) || accept)));
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    unique case (state_q)
      StAccum: begin
        if (close) begin
          out_acc_d   = acc_upd;
          out_count_d = cnt_upd;
          out_ovf_d   = ovf_upd;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          state_d     = StHold;
        end else begin
          acc_d = acc_upd;
          cnt_d = cnt_upd;
          ovf_d = ovf_upd;
        end
      end
      StHold: begin
        if (out_ready) state_d = StAccum;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_adder_result_accumulator.sv
// Bench for adder_result_accumulator: a 32-bit and a 17-bit instance checked against a
// frame-level model plus directed literal expectations.
module tb_adder_result_accumulator;

  localparam int unsigned Cnt = 8;
  localparam int unsigned CW  = 4;
`ifdef ADDER_ACC_SAT_EN
  localparam bit Sat = 1'b1;
`else
  localparam bit Sat = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid  [2];
  logic [15:0] in_sum    [2];
  logic        in_cout   [2];
  logic        flush     [2];
  logic        out_ready [2];

  logic          ir0, ir1, ov0, ov1, ovf0, ovf1;
  logic [31:0]   acc0;
  logic [16:0]   acc1;
  logic [CW-1:0] cnt0, cnt1;

  int n_checks = 0;
  int n_err    = 0;
  bit mon_en   = 1'b0;

  // Frame-level model: only the frame size and the true (unbounded) sum are tracked.
  int unsigned m_size [2];
  longint      m_sum  [2];
  bit          m_held [2];
  longint      m_acc  [2];
  int          m_cnt  [2];
  bit          m_ovf  [2];
  int          aw     [2];

  always #5 clk = ~clk;

  adder_result_accumulator #(.WIDTH(16), .ACC_WIDTH(32), .COUNT(Cnt)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(ir0), .in_sum(in_sum[0]),
    .in_cout(in_cout[0]), .flush(flush[0]), .out_valid(ov0), .out_ready(out_ready[0]),
    .out_acc(acc0), .out_count(cnt0), .out_ovf(ovf0)
  );

  adder_result_accumulator #(.WIDTH(16), .ACC_WIDTH(17), .COUNT(Cnt)) dut17 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(ir1), .in_sum(in_sum[1]),
    .in_cout(in_cout[1]), .flush(flush[1]), .out_valid(ov1), .out_ready(out_ready[1]),
    .out_acc(acc1), .out_count(cnt1), .out_ovf(ovf1)
  );

  function automatic logic g_ir(input int k);  return k == 0 ? ir0 : ir1;   endfunction
  function automatic logic g_ov(input int k);  return k == 0 ? ov0 : ov1;   endfunction
  function automatic logic g_ovf(input int k); return k == 0 ? ovf0 : ovf1; endfunction
  function automatic logic [31:0] g_acc(input int k);
    return k == 0 ? acc0 : {15'd0, acc1};
  endfunction
  function automatic logic [CW-1:0] g_cnt(input int k); return k == 0 ? cnt0 : cnt1; endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare on the negedge, then advance the model with the inputs that the next
  // rising edge will sample.
  always @(negedge clk) begin
    longint lim;
    for (int k = 0; k < 2; k++) begin
      if (mon_en) begin
        chk($sformatf("d%0d_in_ready", k), 64'(g_ir(k)), 64'(!m_held[k]));
        chk($sformatf("d%0d_out_valid", k), 64'(g_ov(k)), 64'(m_held[k]));
        if (m_held[k]) begin
          chk($sformatf("d%0d_out_acc", k), 64'(g_acc(k)), 64'(m_acc[k]));
          chk($sformatf("d%0d_out_count", k), 64'(g_cnt(k)), 64'(m_cnt[k]));
          chk($sformatf("d%0d_out_ovf", k), 64'(g_ovf(k)), 64'(m_ovf[k]));
        end
      end
      if (rst) begin
        m_size[k] = 0;
        m_sum[k]  = 0;
        m_held[k] = 1'b0;
      end else if (!m_held[k]) begin
        if (in_valid[k]) begin
          m_size[k]++;
          m_sum[k] += longint'({in_cout[k], in_sum[k]});
        end
        if (m_size[k] == Cnt || (flush[k] && m_size[k] > 0)) begin
          lim = longint'(1) << aw[k];
          m_ovf[k]  = m_sum[k] >= lim;
          m_acc[k]  = m_ovf[k] ? (Sat ? lim - 1 : m_sum[k] % lim) : m_sum[k];
          m_cnt[k]  = int'(m_size[k]);
          m_held[k] = 1'b1;
          m_size[k] = 0;
          m_sum[k]  = 0;
        end
      end else if (out_ready[k]) begin
        m_held[k] = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int k, input logic c, input logic [15:0] s, input logic fl);
    in_valid[k] = 1'b1;
    in_cout[k]  = c;
    in_sum[k]   = s;
    flush[k]    = fl;
    step();
    in_valid[k] = 1'b0;
    flush[k]    = 1'b0;
  endtask

  task automatic wait_out(input int k, input string name, input logic [31:0] e_acc,
                          input logic [CW-1:0] e_cnt, input logic e_ovf);
    for (int i = 0; i < 20 && !g_ov(k); i++) step();
    chk({name, "_valid"}, 64'(g_ov(k)), 64'd1);
    chk({name, "_acc"}, 64'(g_acc(k)), 64'(e_acc));
    chk({name, "_count"}, 64'(g_cnt(k)), 64'(e_cnt));
    chk({name, "_ovf"}, 64'(g_ovf(k)), 64'(e_ovf));
  endtask

  task automatic handshake(input int k, input string name);
    out_ready[k] = 1'b1;
    step();
    out_ready[k] = 1'b0;
    chk({name, "_ready_after_hs"}, 64'(g_ir(k)), 64'd1);
    chk({name, "_valid_after_hs"}, 64'(g_ov(k)), 64'd0);
  endtask

  initial begin
    aw[0] = 32;
    aw[1] = 17;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0; in_sum[k] = '0; in_cout[k] = 1'b0;
      flush[k] = 1'b0; out_ready[k] = 1'b0;
      m_size[k] = 0; m_sum[k] = 0; m_held[k] = 1'b0;
      m_acc[k] = 0; m_cnt[k] = 0; m_ovf[k] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;

    chk("reset_in_ready", 64'(ir0), 64'd1);
    chk("reset_out_valid", 64'(ov0), 64'd0);
    chk("reset_out_acc", 64'(acc0), 64'd0);
    chk("reset_out_count", 64'(cnt0), 64'd0);
    chk("reset_out_ovf", 64'(ovf0), 64'd0);

    // Full frame of ones.
    for (int i = 0; i < 8; i++) send(0, 1'b0, 16'h0001, 1'b0);
    wait_out(0, "ones", 32'd8, 4'd8, 1'b0);
    step();
    chk("ones_in_ready_held", 64'(ir0), 64'd0);
    handshake(0, "ones");

    // Full frame of the largest result.
    for (int i = 0; i < 8; i++) send(0, 1'b1, 16'hFFFF, 1'b0);
    wait_out(0, "max", 32'h000F_FFF8, 4'd8, 1'b0);
    handshake(0, "max");

    // Early flush without an accompanying accept, then an empty-frame flush.
    for (int i = 0; i < 3; i++) send(0, 1'b0, 16'd5, 1'b0);
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    wait_out(0, "flush3", 32'd15, 4'd3, 1'b0);
    handshake(0, "flush3");
    flush[0] = 1'b1;
    step();
    flush[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_flush_no_valid", 64'(ov0), 64'd0);
      step();
    end

    // Flush together with the closing accept, then a stalled consumer.
    send(0, 1'b0, 16'd10, 1'b0);
    send(0, 1'b0, 16'd20, 1'b0);
    send(0, 1'b0, 16'd30, 1'b1);
    wait_out(0, "flush_acc", 32'd60, 4'd3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      flush[0] = (i == 1);
      step();
      chk("stall_valid", 64'(ov0), 64'd1);
      chk("stall_in_ready", 64'(ir0), 64'd0);
      chk("stall_acc", 64'(acc0), 64'd60);
    end
    flush[0] = 1'b0;
    handshake(0, "flush_acc");
    step();
    chk("hold_flush_forgotten", 64'(ov0), 64'd0);

    // Narrow accumulator overflow.
    send(1, 1'b1, 16'hFFFF, 1'b0);
    send(1, 1'b1, 16'hFFFF, 1'b1);
    wait_out(1, "narrow", Sat ? 32'h1FFFF : 32'h1FFFE, 4'd2, 1'b1);
    handshake(1, "narrow");

    // Reset mid-frame discards the partial frame.
    for (int i = 0; i < 4; i++) send(0, 1'b0, 16'h0001, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_no_valid", 64'(ov0), 64'd0);
      chk("rst_out_acc", 64'(acc0), 64'd0);
      step();
    end
    for (int i = 0; i < 8; i++) send(0, 1'b0, 16'h0001, 1'b0);
    wait_out(0, "after_rst", 32'd8, 4'd8, 1'b0);
    handshake(0, "after_rst");

    // Random traffic on both instances, checked by the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = $urandom_range(0, 3) != 0;
        in_sum[k]    = 16'($urandom);
        in_cout[k]   = 1'($urandom);
        flush[k]     = $urandom_range(0, 12) == 0;
        out_ready[k] = $urandom_range(0, 2) != 0;
      end
      rst = $urandom_range(0, 249) == 0;
      step();
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k] = 1'b0;
      flush[k]    = 1'b0;
    end
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
